lvt_write_scheduler: RTL and testbench
======================================

// Module: lvt_write_scheduler
// PURPOSE
//   Shares the two write ports of the LVT multiport memory among N_REQ write
//   requesters using round-robin arbitration with same-address conflict deferral.
//   After reset, and on demand, it sweeps every index to clear the memory and its
//   live-value array. It sits between the client write masters and the
//   w_en/addr inputs of the live-value/BRAM bank array.
// PARAMETERS
//   N_REQ        4    number of write requesters (1..16)
//   INDEX_WIDTH  8    address width; memory depth = 2**INDEX_WIDTH
//   DATA_WIDTH   32   write data width
//   INIT_VALUE   0    data written to every index during the INIT sweep
// PORTS
//   clk        in   1                    clock, rising edge
//   reset      in   1                    asynchronous, active-low reset
//   req_valid  in   N_REQ                per-requester write request
//   req_addr   in   N_REQ*INDEX_WIDTH    request address; slice i belongs to requester i
//   req_data   in   N_REQ*DATA_WIDTH     request data; slice i belongs to requester i
//   req_ready  out  N_REQ                combinational grant; handshake = valid & ready
//   init_req   in   1                    1-cycle pulse: re-run the clear sweep
//   w_stall    in   1                    memory cannot take a write on the next cycle
//   w_en       out  2                    registered write enables, ports 1:0
//   w_addr     out  2*INDEX_WIDTH        registered; port p uses slice p
//   w_data     out  2*DATA_WIDTH         registered; port p uses slice p
//   init_done  out  1                    registered; 1 while in RUN
// BEHAVIOUR
//   - Reset (asynchronous): state=INIT, sweep counter=0, rr_ptr=0.
//     w_en=0, w_addr=0, w_data=0, init_done=0.
//   - FSM states: INIT and RUN.
//   - INIT:
//     - req_ready=0.
//     - If w_stall=0: issue w_en<=2'b01, w_addr[0]<=cnt, w_data[0]<=INIT_VALUE.
//       Then cnt<=cnt+1.
//     - If w_stall=1: w_en<=0 and cnt holds.
//     - On issuing cnt=2**INDEX_WIDTH-1: cnt wraps to 0, state<=RUN, init_done<=1
//       on the same edge.
//     - init_req is ignored while in INIT.
//   - RUN, grant rules (when w_stall=0 and init_req=0):
//     - Scan requesters from rr_ptr upward, modulo N_REQ.
//     - Slot0 = first valid requester; it goes to port 0.
//     - Slot1 = next valid requester whose addr differs from slot0's addr; it goes
//       to port 1.
//     - A valid requester skipped because its addr equals slot0's addr is a
//       conflict. It stays pending; its data is not dropped.
//     - req_ready=1 only for granted requesters.
//     - Latency 1: w_en/w_addr/w_data update on the edge after the handshake.
//       w_en[p]=0 for an unfilled slot.
//     - rr_ptr <= (index of the last granted requester + 1) mod N_REQ.
//       It is unchanged when nothing is granted.
//   - RUN with w_stall=1: no grants, req_ready=0, w_en<=0.
//   - RUN with init_req=1: no grants that cycle, w_en<=0, state<=INIT, cnt<=0,
//     init_done<=0.
//   - Both ports never carry the same address in one cycle. The LVT therefore never
//     sees a same-index dual write.
//   - N_REQ=1: port 1 is never used.
//   - req_ready never rises without the matching req_valid.
//   - Reset mid-sweep or mid-grant aborts immediately. The sweep restarts from
//     index 0.
// CONFIGURATION
//   LVT_SCHED_STATS_EN
//     - Defined: adds output conflict_cnt[15:0].
//       - Reset value 0.
//       - Increments by 1 in each RUN cycle with at least one conflict-deferred
//         requester.
//       - Saturates at 16'hFFFF.
//       - Cleared when INIT is entered via init_req.
//     - Undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//   1. Reset release, INDEX_WIDTH=4, w_stall=0:
//      -> 16 writes at w_addr[0]=0..15 with w_en=01 on consecutive cycles,
//         then init_done=1.
//   2. RUN, all 4 requesters valid, distinct addrs, rr_ptr=0:
//      -> grants {0,1}, then {2,3}, then {0,1}; each write appears 1 cycle later.
//   3. Requesters 0 and 1 both at addr 5, requester 2 at addr 9:
//      -> grant {0,2}, then {1}. conflict_cnt=1 when LVT_SCHED_STATS_EN is defined.
//   4. w_stall high for 3 cycles during RUN and during INIT at cnt=7:
//      -> req_ready=0, w_en=0 throughout; INIT resumes at index 7.
//   5. init_req pulse while requesters are valid:
//      -> no grant that cycle, init_done=0, full sweep, pending requests served after.
//   6. reset asserted mid-sweep at cnt=10:
//      -> all outputs 0 immediately; after release the sweep restarts at 0.

Source files
------------

// File: rtl/lvt_write_scheduler.sv
// lvt_write_scheduler
//   Shares the two write ports of an LVT multiport memory among N_REQ write
//   requesters. Arbitration is round-robin. A requester whose address matches
//   the port-0 winner is deferred rather than dropped. After reset, and on an
//   init_req pulse, every index is swept with INIT_VALUE to clear the memory and
//   its live-value array.
//   Optional feature macro: LVT_SCHED_STATS_EN adds the conflict_cnt[15:0] output.
module lvt_write_scheduler #(
  parameter int                    N_REQ       = 4,
  parameter int                    INDEX_WIDTH = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*INDEX_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        init_req,
  input  logic                        w_stall,
  output logic [1:0]                  w_en,
  output logic [2*INDEX_WIDTH-1:0]    w_addr,
  output logic [2*DATA_WIDTH-1:0]     w_data,
  output logic                        init_done
`ifdef LVT_SCHED_STATS_EN
  , output logic [15:0]               conflict_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]               w_en_q, w_en_d;
  logic [2*INDEX_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [2*DATA_WIDTH-1:0]  w_data_q, w_data_d;
  logic                     init_done_q, init_done_d;

  logic                     grant_en;
  logic                     slot0_vld, slot1_vld, conflict;
  logic [PTR_W-1:0]         slot0_idx, slot1_idx;
  logic [INDEX_WIDTH-1:0]   slot0_addr;
  logic [PTR_W-1:0]         rr_next;

  assign grant_en = (state_q == ST_RUN) && !w_stall && !init_req;

  // Round-robin scan from rr_ptr: first valid wins port 0, next valid with a
  // different address wins port 1; same-address requesters seen before that are conflicts.
  always_comb begin
    int               pos;
    logic [PTR_W-1:0] idx;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slot0_vld  = 1'b0;
    slot1_vld  = 1'b0;
    conflict   = 1'b0;
    slot0_idx  = '0;
    slot1_idx  = '0;
    slot0_addr = '0;
    pos        = 0;
    idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = PTR_W'(pos);
      if (req_valid[idx] && !slot1_vld) begin
        if (!slot0_vld) begin
          slot0_vld  = 1'b1;
          slot0_idx  = idx;
          slot0_addr = req_addr[idx*INDEX_WIDTH +: INDEX_WIDTH];
        end else if (req_addr[idx*INDEX_WIDTH +: INDEX_WIDTH] == slot0_addr) begin
          conflict = 1'b1;
        end else begin
          slot1_vld = 1'b1;
          slot1_idx = idx;
        end
      end
    end
  end

  // Pointer moves to one past the last granted requester.
  always_comb begin
    int nxt;
    nxt = int'(slot1_vld ? slot1_idx : slot0_idx) + 1;
    if (nxt >= N_REQ) nxt = 0;
    rr_next = PTR_W'(nxt);
  end

  // Combinational grant: only winners of the current scan see ready.
  always_comb begin
    req_ready = '0;
    if (grant_en) begin
      if (slot0_vld) req_ready[slot0_idx] = 1'b1;
      if (slot1_vld) req_ready[slot1_idx] = 1'b1;
    end
  end

  // Next-state and registered write-port outputs for the INIT sweep and RUN grants.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    w_en_d   = 2'b00;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    unique case (state_q)
      ST_INIT: begin
        if (!w_stall) begin
          w_en_d                        = 2'b01;
          w_addr_d[INDEX_WIDTH-1:0]     = cnt_q;
          w_data_d[DATA_WIDTH-1:0]      = INIT_VALUE;
          cnt_d                         = cnt_q + 1'b1;
          if (&cnt_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (grant_en) begin
          w_en_d = {slot1_vld, slot0_vld};
          if (slot0_vld) begin
            w_addr_d[INDEX_WIDTH-1:0] = slot0_addr;
            w_data_d[DATA_WIDTH-1:0]  = req_data[slot0_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d                  = rr_next;
          end
          if (slot1_vld) begin
            w_addr_d[INDEX_WIDTH +: INDEX_WIDTH] = req_addr[slot1_idx*INDEX_WIDTH +: INDEX_WIDTH];
            w_data_d[DATA_WIDTH +: DATA_WIDTH]   = req_data[slot1_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // State and output registers; reset aborts any sweep or grant in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      w_en_q      <= 2'b00;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // sample the same pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign w_en      = w_en_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign init_done = init_done_q;

`ifdef LVT_SCHED_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of RUN cycles that deferred a same-address requester.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == ST_RUN && init_req) begin
      conflict_cnt_d = '0;
    end else if (grant_en && conflict && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  // Conflict detection has no consumer when statistics are compiled out.
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_lvt_write_scheduler.sv
// tb_lvt_write_scheduler
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the scheduler (sweep index, round-robin order list,
//   conflict deferral) kept in this bench.
//   Build with LVT_SCHED_STATS_EN defined to also check conflict_cnt.
module tb_lvt_write_scheduler;

  localparam int          N     = 4;
  localparam int          IW    = 4;
  localparam int          DW    = 32;
  localparam int          DEPTH = 1 << IW;
  localparam logic [DW-1:0] INITV = 32'h5A5A_0001;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*IW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              init_req;
  logic              w_stall;
  logic [1:0]        w_en;
  logic [2*IW-1:0]   w_addr;
  logic [2*DW-1:0]   w_data;
  logic              init_done;
`ifdef LVT_SCHED_STATS_EN
  logic [15:0]       conflict_cnt;
`endif

  lvt_write_scheduler #(
    .N_REQ      (N),
    .INDEX_WIDTH(IW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (INITV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_req  (init_req),
    .w_stall   (w_stall),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .init_done (init_done)
`ifdef LVT_SCHED_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the write ports must show after the next edge.
  bit            m_init;
  int            m_sweep;
  int            m_rr;
  logic [1:0]    m_wen;
  logic [IW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  bit            m_done;
  int            m_cc;
  logic [N-1:0]  obs_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init  = 1'b1;
    m_sweep = 0;
    m_rr    = 0;
    m_wen   = 2'b00;
    m_addr  = '{default: '0};
    m_data  = '{default: '0};
    m_done  = 1'b0;
    m_cc    = 0;
  endtask

  // One clock cycle: at the falling edge compare DUT outputs with the model,
  // advance the model, then return 1 time unit after the next rising edge with
  // granted requests retired and init_req dropped.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int           order[$];
    int           g0, g1, c;
    bit           confl;
    @(negedge clk);
    check("init_done", init_done, m_done);
    check("w_en", w_en, m_wen);
    for (int p = 0; p < 2; p++) begin
      if (m_wen[p]) begin
        check($sformatf("w_addr%0d", p), w_addr[p*IW +: IW], m_addr[p]);
        check($sformatf("w_data%0d", p), w_data[p*DW +: DW], m_data[p]);
      end
    end
    check("ports_distinct", (w_en == 2'b11) && (w_addr[IW-1:0] == w_addr[IW +: IW]), 0);
`ifdef LVT_SCHED_STATS_EN
    check("conflict_cnt", conflict_cnt, m_cc);
`endif
    exp_ready = '0;
    g0 = -1;
    g1 = -1;
    confl = 1'b0;
    if (m_init) begin
      if (!w_stall) begin
        m_wen     = 2'b01;
        m_addr[0] = IW'(m_sweep);
        m_data[0] = INITV;
        if (m_sweep == DEPTH - 1) begin
          m_init  = 1'b0;
          m_sweep = 0;
        end else begin
          m_sweep++;
        end
      end else begin
        m_wen = 2'b00;
      end
    end else if (init_req) begin
      m_wen   = 2'b00;
      m_init  = 1'b1;
      m_sweep = 0;
      m_cc    = 0;
    end else if (w_stall) begin
      m_wen = 2'b00;
    end else begin
      for (int k = 0; k < N; k++)
        if (req_valid[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
      if (order.size() > 0) begin
        g0 = order.pop_front();
        while (order.size() > 0) begin
          c = order.pop_front();
          if (req_addr[c*IW +: IW] == req_addr[g0*IW +: IW]) confl = 1'b1;
          else begin
            g1 = c;
            break;
          end
        end
      end
      m_wen = {g1 >= 0, g0 >= 0};
      if (g0 >= 0) begin
        exp_ready[g0] = 1'b1;
        m_addr[0] = req_addr[g0*IW +: IW];
        m_data[0] = req_data[g0*DW +: DW];
        m_rr      = ((g1 >= 0 ? g1 : g0) + 1) % N;
      end
      if (g1 >= 0) begin
        exp_ready[g1] = 1'b1;
        m_addr[1] = req_addr[g1*IW +: IW];
        m_data[1] = req_data[g1*DW +: DW];
      end
      if (confl && m_cc < 16'hFFFF) m_cc++;
    end
    m_done = !m_init;
    check("req_ready", req_ready, exp_ready);
    check("ready_without_valid", req_ready & ~req_valid, 0);
    obs_ready = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~obs_ready;
    init_req  = 1'b0;
  endtask

  task automatic set_req(input int i, input int a);
    req_valid[i]        = 1'b1;
    req_addr[i*IW +: IW] = IW'(a);
    req_data[i*DW +: DW] = $urandom;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    init_req  = 1'b0;
    w_stall   = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_w_en", w_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_init_done", init_done, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Sweep after reset: indices 0..15 on consecutive cycles, then init_done.
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("t1_w_en", w_en, 2'b01);
      check("t1_idx", w_addr[IW-1:0], i);
    end
    check("t1_init_done", init_done, 1);

    // All four valid, distinct addresses: pairs alternate from rr_ptr=0.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) set_req(i, i + 1);
      cycle();
      check("t2_grant", obs_ready, (r % 2 == 0) ? 4'b0011 : 4'b1100);
      check("t2_addr", w_addr, (r % 2 == 0) ? {4'd2, 4'd1} : {4'd4, 4'd3});
    end

    // Same-address conflict: 0 and 1 at 5, 2 at 9.
    set_req(0, 5);
    set_req(1, 5);
    set_req(2, 9);
    cycle();
    check("t3_grant_a", obs_ready, 4'b0101);
    check("t3_w_en_a", w_en, 2'b11);
    cycle();
    check("t3_grant_b", obs_ready, 4'b0010);
    check("t3_w_en_b", w_en, 2'b01);
    check("t3_addr_b", w_addr[IW-1:0], 5);
`ifdef LVT_SCHED_STATS_EN
    check("t3_conflict_cnt", conflict_cnt, 1);
`endif

    // Stall during RUN for 3 cycles.
    for (int i = 0; i < N; i++) set_req(i, i + 1);
    w_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cycle();
      check("t4_run_ready", obs_ready, 0);
      check("t4_run_w_en", w_en, 0);
    end
    w_stall = 1'b0;

    // init_req with requesters pending, plus a 3-cycle stall at sweep index 7.
    init_req = 1'b1;
    cycle();
    check("t5_no_grant", obs_ready, 0);
    check("t5_init_done", init_done, 0);
    for (int i = 0; i < 7; i++) cycle();
    w_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      cycle();
      check("t4_init_w_en", w_en, 0);
      check("t4_init_ready", obs_ready, 0);
    end
    w_stall = 1'b0;
    cycle();
    check("t4_resume_idx", w_addr[IW-1:0], 7);
    for (int i = 8; i < DEPTH; i++) cycle();
    check("t5_done", init_done, 1);
    cycle();
    check("t5_pending_served", obs_ready, 4'b1100);

    // Reset in the middle of a sweep at index 10.
    init_req = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    check("t6_pre_idx", w_addr[IW-1:0], 9);
    reset = 1'b0;
    #1;
    check("t6_w_en", w_en, 0);
    check("t6_w_addr", w_addr, 0);
    check("t6_w_data", w_data, 0);
    check("t6_init_done", init_done, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle();
    check("t6_restart_idx", w_addr[IW-1:0], 0);
    check("t6_restart_w_en", w_en, 2'b01);
    for (int i = 1; i < DEPTH; i++) cycle();

    // Random traffic with a narrow address range to provoke conflicts.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 9) < 6) set_req(i, $urandom_range(0, 3));
      w_stall  = ($urandom_range(0, 9) == 0);
      init_req = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
